// File: rtl/dm_port_arbiter_pkg.sv
// dm_port_arbiter_pkg
// Shared types and constants for the data-memory port arbiter:
//   state_e    - arbiter FSM states
//   dm_size_t  - DM write-size encoding (SZ_WORD/SZ_BYTE/SZ_HALF/SZ_3B)
//   DM_SENTINEL- load data returned when a transaction times out
package dm_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LD_BUSY = 2'd1,
    S_ST_BUSY = 2'd2,
    S_TURN    = 2'd3
  } state_e;

  typedef logic [1:0] dm_size_t;

  localparam dm_size_t SZ_WORD = 2'd0;
  localparam dm_size_t SZ_BYTE = 2'd1;
  localparam dm_size_t SZ_HALF = 2'd2;
  localparam dm_size_t SZ_3B   = 2'd3;

  localparam logic [31:0] DM_SENTINEL = 32'hDEAD_BEEF;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if
// Handshake bundle between the arbiter and the data cache.
//   master : arbiter side (drives address/data/size/strobes, receives read data + valid)
//   slave  : cache side
interface dm_port_arbiter_if;
  import dm_port_arbiter_pkg::*;

  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  dm_size_t    data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic        MemFlush_2DM;
  logic [31:0] data_read_fDM;
  logic        data_valid_fDM;

  modport master (
    output data_address_2DM, data_write_2DM, data_write_size_2DM,
           MemRead_2DM, MemWrite_2DM, MemFlush_2DM,
    input  data_read_fDM, data_valid_fDM
  );

  modport slave (
    input  data_address_2DM, data_write_2DM, data_write_size_2DM,
           MemRead_2DM, MemWrite_2DM, MemFlush_2DM,
    output data_read_fDM, data_valid_fDM
  );

endinterface

// File: rtl/dm_arb_select.sv
// dm_arb_select
// Priority decision between the load path and the store/flush path, plus the
// saturating count of consecutive load grants taken while a store waited.
//   CLK, RESET        : clock, synchronous active-low reset
//   arb_en            : arbiter is in IDLE and may grant this cycle
//   ld_req, st_req    : requests
//   st_full           : store queue full, store takes priority
//   ld_win, st_win    : grant decision for this cycle (mutually exclusive)
module dm_arb_select #(
  parameter int MAX_LD_STREAK = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic arb_en,
  input  logic ld_req,
  input  logic st_req,
  input  logic st_full,
  output logic ld_win,
  output logic st_win
);

  localparam int SW = $clog2(MAX_LD_STREAK + 1);

  logic [SW-1:0] streak;
  logic          streak_max;

  assign streak_max = (streak == SW'(MAX_LD_STREAK));

  // A waiting store is only starved for MAX_LD_STREAK load grants in a row.
  assign st_win = arb_en && st_req && (st_full || streak_max || !ld_req);
  assign ld_win = arb_en && ld_req && !st_win;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      streak <= '0;
    end else if (st_win) begin
      streak <= '0;
    end else if (ld_win && st_req && !streak_max) begin
      streak <= streak + SW'(1);
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares the single data-memory port between the MEM-stage load path and the
// store-drain/flush path, runs each transaction over the DM handshake and
// returns completion pulses and load data.
//   CLK, RESET          : clock, synchronous active-low reset
//   ld_req/ld_addr      : load request and byte address
//   ld_gnt/ld_done      : load payload latched / load data valid on ld_rdata
//   ld_rdata            : raw DM word of the last completed load
//   st_req/st_flush/st_full/st_addr/st_wdata/st_size : store or flush request
//   st_gnt/st_done      : store payload latched / store or flush completed
//   dm                  : DM handshake (master side)
//   err_timeout         : sticky, some transaction was aborted on timeout
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int MAX_LD_STREAK = 4,
  parameter int TIMEOUT       = 64,
  parameter int CNT_W         = 7
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic        st_flush,
  input  logic        st_full,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  dm_size_t    st_size,
  output logic        st_gnt,
  output logic        st_done,
  dm_port_arbiter_if.master dm,
  output logic        err_timeout
);

  state_e         state;
  logic [CNT_W-1:0] tmo_cnt;
  logic           arb_en;
  logic           ld_win;
  logic           st_win;
  logic           tmo_hit;
  logic           unused_ld_addr_lsb;

  // Loads always fetch the aligned word; the byte offset is handled upstream.
  assign unused_ld_addr_lsb = ^ld_addr[1:0];

  assign arb_en  = (state == S_IDLE);
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  dm_arb_select #(
    .MAX_LD_STREAK(MAX_LD_STREAK)
  ) u_select (
    .CLK    (CLK),
    .RESET  (RESET),
    .arb_en (arb_en),
    .ld_req (ld_req),
    .st_req (st_req),
    .st_full(st_full),
    .ld_win (ld_win),
    .st_win (st_win)
  );

  // Grants are decided from this cycle's inputs; the payload is registered at
  // the end of the grant cycle.
  assign ld_gnt = ld_win;
  assign st_gnt = st_win;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state                  <= S_IDLE;
      tmo_cnt                <= '0;
      ld_done                <= 1'b0;
      st_done                <= 1'b0;
      ld_rdata               <= '0;
      err_timeout            <= 1'b0;
      dm.data_address_2DM    <= '0;
      dm.data_write_2DM      <= '0;
      dm.data_write_size_2DM <= SZ_WORD;
      dm.MemRead_2DM         <= 1'b0;
      dm.MemWrite_2DM        <= 1'b0;
      dm.MemFlush_2DM        <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      st_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (st_win) begin
            state                  <= S_ST_BUSY;
            dm.data_address_2DM    <= st_addr;
            dm.data_write_2DM      <= st_wdata;
            dm.data_write_size_2DM <= st_size;
            dm.MemWrite_2DM        <= !st_flush;
            dm.MemFlush_2DM        <= st_flush;
          end else if (ld_win) begin
            state               <= S_LD_BUSY;
            dm.data_address_2DM <= {ld_addr[31:2], 2'b00};
            dm.MemRead_2DM      <= 1'b1;
          end
        end
        S_LD_BUSY: begin
          if (dm.data_valid_fDM || tmo_hit) begin
            state          <= S_TURN;
            ld_done        <= 1'b1;
            dm.MemRead_2DM <= 1'b0;
            if (dm.data_valid_fDM) begin
              ld_rdata <= dm.data_read_fDM;
            end else begin
              ld_rdata    <= DM_SENTINEL;
              err_timeout <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_ST_BUSY: begin
          if (dm.data_valid_fDM || tmo_hit) begin
            state           <= S_TURN;
            st_done         <= 1'b1;
            dm.MemWrite_2DM <= 1'b0;
            dm.MemFlush_2DM <= 1'b0;
            if (!dm.data_valid_fDM) begin
              err_timeout <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_TURN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_gnt;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic        st_flush;
  logic        st_full;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [1:0]  st_size;
  logic        st_gnt;
  logic        st_done;
  logic        err_timeout;

  int n_checks;
  int n_fail;

  dm_port_arbiter_if dm ();

  dm_port_arbiter #(
    .MAX_LD_STREAK(4),
    .TIMEOUT      (64),
    .CNT_W        (7)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_gnt     (ld_gnt),
    .ld_done    (ld_done),
    .ld_rdata   (ld_rdata),
    .st_req     (st_req),
    .st_flush   (st_flush),
    .st_full    (st_full),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .st_size    (st_size),
    .st_gnt     (st_gnt),
    .st_done    (st_done),
    .dm         (dm.master),
    .err_timeout(err_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] strobes();
    return {dm.MemRead_2DM, dm.MemWrite_2DM, dm.MemFlush_2DM};
  endfunction

  initial begin
    int          bad;
    int          ng;
    int          done_cnt;
    logic [5:0]  gseq;
    logic [5:0]  exp_seq;

    n_checks = 0;
    n_fail   = 0;
    RESET    = 1'b0;
    ld_req   = 1'b0;
    ld_addr  = '0;
    st_req   = 1'b0;
    st_flush = 1'b0;
    st_full  = 1'b0;
    st_addr  = '0;
    st_wdata = '0;
    st_size  = '0;
    dm.data_read_fDM  = '0;
    dm.data_valid_fDM = 1'b0;

    // ---------------- reset state
    cyc();
    cyc();
    #1;
    check("rst_strobes", 32'(strobes()), 32'h0);
    check("rst_addr", dm.data_address_2DM, 32'h0);
    check("rst_done", {30'h0, ld_done, st_done}, 32'h0);
    check("rst_rdata", ld_rdata, 32'h0);
    check("rst_err", 32'(err_timeout), 32'h0);
    cyc();
    RESET = 1'b1;
    cyc();

    // ---------------- load, valid one cycle after strobe
    ld_req  = 1'b1;
    ld_addr = 32'h0000_1003;
    #1;
    check("ld1_gnt", {30'h0, ld_gnt, st_gnt}, 32'h2);
    check("ld1_no_strobe_t", 32'(strobes()), 32'h0);
    cyc();
    ld_req  = 1'b0;
    ld_addr = 32'hFFFF_FFFF;
    #1;
    check("ld1_read_t1", 32'(strobes()), 32'h4);
    check("ld1_addr_t1", dm.data_address_2DM, 32'h0000_1000);
    check("ld1_gnt_t1", 32'(ld_gnt), 32'h0);
    cyc();
    dm.data_valid_fDM = 1'b1;
    dm.data_read_fDM  = 32'hA5A5_0001;
    #1;
    check("ld1_read_t2", 32'(strobes()), 32'h4);
    check("ld1_done_early", 32'(ld_done), 32'h0);
    cyc();
    dm.data_valid_fDM = 1'b0;
    dm.data_read_fDM  = 32'h1234_5678;
    #1;
    check("ld1_done", 32'(ld_done), 32'h1);
    check("ld1_rdata", ld_rdata, 32'hA5A5_0001);
    check("ld1_turn_strobes", 32'(strobes()), 32'h0);
    cyc();
    #1;
    check("ld1_done_once", 32'(ld_done), 32'h0);
    check("ld1_rdata_hold", ld_rdata, 32'hA5A5_0001);
    cyc();

    // ---------------- byte store, valid after 5 wait cycles
    st_req   = 1'b1;
    st_size  = SZ_BYTE;
    st_addr  = 32'h0000_2002;
    st_wdata = 32'h0000_00FF;
    #1;
    check("st1_gnt", {30'h0, ld_gnt, st_gnt}, 32'h1);
    cyc();
    st_req   = 1'b0;
    st_addr  = 32'h0000_9999;
    st_wdata = 32'h0;
    st_size  = SZ_WORD;
    bad      = 0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (strobes() != 3'b010 || dm.data_address_2DM != 32'h2002 ||
          dm.data_write_size_2DM != 2'd1 || dm.data_write_2DM != 32'hFF || st_done)
        bad++;
      cyc();
    end
    check("st1_stable", 32'(bad), 32'h0);
    dm.data_valid_fDM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (st_done) done_cnt++;
      cyc();
      dm.data_valid_fDM = 1'b0;
    end
    check("st1_done_once", 32'(done_cnt), 32'h1);
    check("st1_strobes_off", 32'(strobes()), 32'h0);
    check("st1_rdata_kept", ld_rdata, 32'hA5A5_0001);

    // ---------------- flush
    st_req   = 1'b1;
    st_flush = 1'b1;
    st_addr  = 32'h0000_3000;
    #1;
    check("fl_gnt", 32'(st_gnt), 32'h1);
    cyc();
    st_req   = 1'b0;
    st_flush = 1'b0;
    bad      = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (strobes() != 3'b001 || dm.data_address_2DM != 32'h3000) bad++;
      cyc();
    end
    dm.data_valid_fDM = 1'b1;
    #1;
    if (strobes() != 3'b001) bad++;
    check("fl_strobes", 32'(bad), 32'h0);
    cyc();
    dm.data_valid_fDM = 1'b0;
    #1;
    check("fl_done", {30'h0, ld_done, st_done}, 32'h1);
    cyc();
    cyc();

    // ---------------- streak: both held, zero-wait completions
    exp_seq = 6'b010000;
    gseq    = '0;
    ng      = 0;
    dm.data_valid_fDM = 1'b1;
    dm.data_read_fDM  = 32'h0;
    ld_req = 1'b1;
    st_req = 1'b1;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #1;
      if (ld_gnt || st_gnt) begin
        gseq[ng] = st_gnt;
        ng++;
      end
      cyc();
    end
    ld_req = 1'b0;
    st_req = 1'b0;
    check("streak_count", 32'(ng), 32'h6);
    for (int i = 0; i < 6; i++)
      check($sformatf("streak_g%0d", i), 32'(gseq[i]), 32'(exp_seq[i]));
    for (int i = 0; i < 4; i++) cyc();

    st_full = 1'b1;
    ld_req  = 1'b1;
    st_req  = 1'b1;
    #1;
    check("full_st_wins", {30'h0, ld_gnt, st_gnt}, 32'h1);
    cyc();
    ld_req  = 1'b0;
    st_req  = 1'b0;
    st_full = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    dm.data_valid_fDM = 1'b0;
    check("pre_tmo_err", 32'(err_timeout), 32'h0);

    // ---------------- load timeout
    ld_req  = 1'b1;
    ld_addr = 32'h0000_4000;
    #1;
    check("tmo_gnt", 32'(ld_gnt), 32'h1);
    cyc();
    ld_req = 1'b0;
    bad    = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (strobes() != 3'b100 || ld_done) bad++;
      cyc();
    end
    check("tmo_busy64", 32'(bad), 32'h0);
    #1;
    check("tmo_done", 32'(ld_done), 32'h1);
    check("tmo_rdata", ld_rdata, 32'hDEAD_BEEF);
    check("tmo_err", 32'(err_timeout), 32'h1);
    check("tmo_strobes", 32'(strobes()), 32'h0);
    for (int i = 0; i < 5; i++) cyc();
    check("tmo_err_sticky", 32'(err_timeout), 32'h1);

    // ---------------- reset in the middle of a store
    st_req   = 1'b1;
    st_addr  = 32'h0000_5000;
    st_wdata = 32'h1111_2222;
    #1;
    check("rs_gnt", 32'(st_gnt), 32'h1);
    cyc();
    st_req = 1'b0;
    RESET  = 1'b0;
    #1;
    check("rs_busy", 32'(strobes()), 32'h2);
    cyc();
    RESET = 1'b1;
    dm.data_valid_fDM = 1'b1;
    #1;
    check("rs_strobes", 32'(strobes()), 32'h0);
    check("rs_no_done", {30'h0, ld_done, st_done}, 32'h0);
    check("rs_err_clr", 32'(err_timeout), 32'h0);
    cyc();
    dm.data_valid_fDM = 1'b0;
    #1;
    check("rs_valid_ignored", {29'h0, ld_done, st_done, dm.MemWrite_2DM}, 32'h0);
    cyc();
    ld_req  = 1'b1;
    ld_addr = 32'h0000_6006;
    #1;
    check("rs_ld_gnt", 32'(ld_gnt), 32'h1);
    cyc();
    ld_req = 1'b0;
    dm.data_valid_fDM = 1'b1;
    dm.data_read_fDM  = 32'hCAFE_0042;
    #1;
    check("rs_ld_addr", dm.data_address_2DM, 32'h0000_6004);
    cyc();
    dm.data_valid_fDM = 1'b0;
    #1;
    check("rs_ld_done", 32'(ld_done), 32'h1);
    check("rs_ld_rdata", ld_rdata, 32'hCAFE_0042);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
